// File: rtl/seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_control_unit
// Purpose  : Multi-cycle fetch/decode/mem/writeback sequencer with registered
//            outputs, HALT detection and a saturating retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_control_unit #(
    parameter int                         ADDR_W     = 6,
    parameter int                         OP_W       = 4,
    parameter int                         REG_W      = 4,
    parameter logic [OP_W+3*REG_W-1:0]    HALT_INSTR = 16'hFF00,
    parameter logic [OP_W-1:0]            OP_LW      = 4'b1001,
    parameter logic [OP_W-1:0]            OP_SW      = 4'b1010,
    parameter logic [OP_W-1:0]            OP_JR      = 4'b1111,
    parameter int                         CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [ADDR_W-1:0]             pc_off,
    input  logic [OP_W+3*REG_W-1:0]       rom_data,
    input  logic                          ram_ack,
    output logic [2:0]                    state,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_en,
    output logic [OP_W-1:0]               opcode,
    output logic [REG_W-1:0]              rd,
    output logic [REG_W-1:0]              rs,
    output logic [REG_W-1:0]              rt,
    output logic                          ram_req,
    output logic                          done,
    output logic [CNT_W-1:0]              retired
);

    localparam int INSTR_W = OP_W + 3*REG_W;

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_DONE   = 3'b101
    } state_t;

    state_t             r_state,   w_next_state;
    logic [ADDR_W-1:0]  r_pc,      w_next_pc;
    logic [OP_W-1:0]    r_opcode,  w_next_opcode;
    logic [REG_W-1:0]   r_rd,      w_next_rd;
    logic [REG_W-1:0]   r_rs,      w_next_rs;
    logic [REG_W-1:0]   r_rt,      w_next_rt;
    logic [CNT_W-1:0]   r_retired, w_next_retired;
    logic               r_rom_en,  w_next_rom_en;
    logic               r_ram_req;
    logic               r_done;

    logic [OP_W-1:0]    w_dec_op;

    assign w_dec_op = rom_data[INSTR_W-1 -: OP_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RESET;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_retired <= '0;
            r_rom_en  <= 1'b0;
            r_ram_req <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_opcode  <= w_next_opcode;
            r_rd      <= w_next_rd;
            r_rs      <= w_next_rs;
            r_rt      <= w_next_rt;
            r_retired <= w_next_retired;
            r_rom_en  <= w_next_rom_en;
            r_ram_req <= (w_next_state == ST_MEM);
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    // rom_en is registered, so a read interrupted by stall is re-issued one
    // cycle later and FETCH only advances after a cycle with rom_en high.
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_opcode  = r_opcode;
        w_next_rd      = r_rd;
        w_next_rs      = r_rs;
        w_next_rt      = r_rt;
        w_next_retired = r_retired;
        w_next_rom_en  = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_next_state  = ST_FETCH;
                w_next_rom_en = 1'b1;
            end
            ST_FETCH: begin
                if (!stall) begin
                    if (r_rom_en) begin
                        w_next_state = ST_DECODE;
                    end else begin
                        w_next_rom_en = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    if (rom_data == HALT_INSTR) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_opcode = w_dec_op;
                        w_next_rd     = rom_data[3*REG_W-1 -: REG_W];
                        w_next_rs     = rom_data[2*REG_W-1 -: REG_W];
                        w_next_rt     = rom_data[REG_W-1:0];
                        w_next_state  = ((w_dec_op == OP_LW) || (w_dec_op == OP_SW)) ? ST_MEM : ST_WB;
                    end
                end
            end
            ST_MEM: begin
                if (!stall && ram_ack) begin
                    w_next_state = ST_WB;
                end
            end
            ST_WB: begin
                if (!stall) begin
                    w_next_pc     = (r_opcode == OP_JR) ? pc_off : (r_pc + pc_off);
                    w_next_state  = ST_FETCH;
                    w_next_rom_en = 1'b1;
                    if (r_retired != {CNT_W{1'b1}}) begin
                        w_next_retired = r_retired + 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_DONE;
            end
        endcase
    end

    assign state    = r_state;
    assign rom_addr = r_pc;
    assign rom_en   = r_rom_en;
    assign opcode   = r_opcode;
    assign rd       = r_rd;
    assign rs       = r_rs;
    assign rt       = r_rt;
    assign ram_req  = r_ram_req;
    assign done     = r_done;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_control_unit
// Purpose  : Self-checking bench; instruction-level reference model of the
//            sequencer compared against observed fetch/writeback behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_control_unit;

    localparam logic [15:0] c_HALT = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        ram_ack = 1'b0;
    logic [5:0]  pc_off;
    logic [15:0] rom_data, rom_data2;

    logic [2:0]  state, state2;
    logic [5:0]  rom_addr, rom_addr2;
    logic        rom_en, rom_en2, ram_req, ram_req2, done, done2;
    logic [3:0]  opcode, rd, rs, rt, opcode2, rd2, rs2, rt2;
    logic [15:0] retired;
    logic [1:0]  retired2;

    logic [15:0] rom     [64];
    logic [5:0]  off_tab [64];

    int n_cmp = 0;
    int n_bad = 0;

    int stall_mode = 0;
    int fixed_delay = 0;
    int mem_cnt = 0;
    int cur_delay = 1;
    int cyc = 0;

    int          delay_q [$];
    int          req_q   [$];
    int          fetch_q [$];
    int          issue_q [$];
    int          dec_t   [$];
    logic [15:0] wb_q    [$];
    int          req_run = 0;
    logic [2:0]  prev_state = 3'd0;
    logic        prev_rom_en = 1'b0;

    seq_control_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_off(pc_off),
        .rom_data(rom_data), .ram_ack(ram_ack), .state(state),
        .rom_addr(rom_addr), .rom_en(rom_en), .opcode(opcode), .rd(rd),
        .rs(rs), .rt(rt), .ram_req(ram_req), .done(done), .retired(retired)
    );

    seq_control_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .pc_off(pc_off),
        .rom_data(rom_data2), .ram_ack(ram_ack), .state(state2),
        .rom_addr(rom_addr2), .rom_en(rom_en2), .opcode(opcode2), .rd(rd2),
        .rs(rs2), .rt(rt2), .ram_req(ram_req2), .done(done2), .retired(retired2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign pc_off = off_tab[rom_addr];

    // Synchronous ROM, one cycle latency, output held while not enabled
    always @(posedge clk) begin
        if (rom_en)  rom_data  <= rom[rom_addr];
        if (rom_en2) rom_data2 <= rom[rom_addr2];
    end

    // RAM responder and stall generator
    always @(negedge clk) begin
        if (ram_req) begin
            mem_cnt++;
            if (mem_cnt == 1) begin
                cur_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
                delay_q.push_back(cur_delay);
            end
            ram_ack = (mem_cnt >= cur_delay);
        end else begin
            mem_cnt = 0;
            ram_ack = 1'b0;
        end
        case (stall_mode)
            1:       stall = ($urandom_range(0, 3) == 0);
            2:       stall = ram_req && (mem_cnt == cur_delay || mem_cnt == cur_delay + 1);
            default: stall = 1'b0;
        endcase
    end

    // Observer: one record per DECODE entry, per WB entry and per RAM request
    always @(negedge clk) begin
        if (!reset) begin
            prev_state  = 3'd0;
            prev_rom_en = 1'b0;
            req_run     = 0;
        end else begin
            if (ram_req) begin
                req_run++;
            end else if (req_run != 0) begin
                req_q.push_back(req_run);
                req_run = 0;
            end
            if (state == 3'd2 && prev_state != 3'd2) begin
                fetch_q.push_back(int'(rom_addr));
                issue_q.push_back(int'(prev_rom_en));
                dec_t.push_back(cyc);
            end
            if (state == 3'd4 && prev_state != 3'd4) wb_q.push_back({opcode, rd, rs, rt});
            prev_state  = state;
            prev_rom_en = rom_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_run(input int mode, input int fdly);
        reset = 1'b0;
        stall_mode = mode;
        fixed_delay = fdly;
        repeat (2) @(negedge clk);
        fetch_q.delete(); issue_q.delete(); dec_t.delete();
        wb_q.delete(); req_q.delete(); delay_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, " done"}, done, 1);
    endtask

    // Run the loaded program and compare against the instruction-level model
    task automatic run_prog(input string name, input int mode, input int fdly);
        int          exp_pc [$];
        logic [15:0] exp_ins[$];
        int          pc, n, hits, j, e;
        logic [15:0] w;
        logic [3:0]  op;
        pc = 0;
        n  = 0;
        for (int k = 0; k < 64; k++) begin
            exp_pc.push_back(pc);
            w = rom[pc];
            if (w == c_HALT) break;
            exp_ins.push_back(w);
            n++;
            if (w[15:12] == 4'hF) pc = int'(off_tab[pc]);
            else                  pc = (pc + int'(off_tab[pc])) % 64;
        end
        start_run(mode, fdly);
        wait_done(name);
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (rom_en) hits++;
        end
        check({name, " rom_en quiet"}, hits, 0);
        check({name, " state"}, state, 3'b101);
        check({name, " ram_req"}, ram_req, 0);
        check({name, " final pc"}, rom_addr, exp_pc[exp_pc.size()-1]);
        check({name, " retired"}, retired, n);
        check({name, " retired sat"}, retired2, (n > 3) ? 3 : n);
        check({name, " fetch count"}, fetch_q.size(), exp_pc.size());
        for (int i = 0; i < exp_pc.size() && i < fetch_q.size(); i++) begin
            check({name, " fetch addr"}, fetch_q[i], exp_pc[i]);
            check({name, " rom_en issued"}, issue_q[i], 1);
        end
        check({name, " wb count"}, wb_q.size(), n);
        for (int i = 0; i < n && i < wb_q.size(); i++)
            check({name, " fields"}, wb_q[i], exp_ins[i]);
        if (mode != 1) begin
            j = 0;
            for (int i = 1; i < dec_t.size() && i <= n; i++) begin
                e  = 3;
                op = exp_ins[i-1][15:12];
                if (op == 4'h9 || op == 4'hA) begin
                    if (j < delay_q.size() && j < req_q.size()) begin
                        e += delay_q[j] + ((mode == 2) ? 2 : 0);
                        check({name, " ram_req len"}, req_q[j], delay_q[j] + ((mode == 2) ? 2 : 0));
                    end else begin
                        check({name, " ram request seen"}, 0, 1);
                    end
                    j++;
                end
                check({name, " latency"}, dec_t[i] - dec_t[i-1], e);
            end
        end
    endtask

    task automatic clear_mem(input logic [5:0] off);
        for (int a = 0; a < 64; a++) begin
            rom[a]     = c_HALT;
            off_tab[a] = off;
        end
    endtask

    initial begin
        int          off, len;
        logic [3:0]  rop;
        logic [11:0] rlow;
        clear_mem(6'd1);
        rom[0] = 16'h1234;
        rom[1] = 16'h2345;
        rom[2] = c_HALT;
        #2 reset = 1'b0;
        #1;
        check("async reset state", state, 0);
        check("async reset outputs", {rom_addr, rom_en, ram_req, done, retired}, 0);
        repeat (2) @(negedge clk);
        check("reset fields", {opcode, rd, rs, rt}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("c1 state", state, 1);
        check("c1 rom_en", rom_en, 1);
        check("c1 addr", rom_addr, 0);
        @(negedge clk);
        check("c2 state", state, 2);
        check("c2 rom_en", rom_en, 0);
        @(negedge clk);
        check("c3 state", state, 4);
        check("c3 fields", {opcode, rd, rs, rt}, 16'h1234);
        @(negedge clk);
        check("c4 state", state, 1);
        check("c4 pc", rom_addr, 1);
        check("c4 retired", retired, 1);
        check("c4 rom_en", rom_en, 1);
        repeat (3) @(negedge clk);
        check("fetch2 addr", rom_addr, 2);
        check("fetch2 rom_en", rom_en, 1);
        repeat (2) @(negedge clk);
        check("halt state", state, 3'b101);
        check("halt done", done, 1);
        check("halt pc", rom_addr, 2);
        check("halt retired", retired, 2);
        check("halt rom_en", rom_en, 0);

        clear_mem(6'd1);
        rom[0] = 16'h9123;
        run_prog("lw", 0, 3);
        run_prog("lw stall", 2, 3);

        clear_mem(6'd1);
        rom[0] = 16'hF123; off_tab[0] = 6'd5;
        rom[5] = 16'h1000; off_tab[5] = 6'd58;
        rom[63] = 16'h1000; off_tab[63] = 6'd3;
        run_prog("jr wrap", 0, 0);

        clear_mem(6'd1);
        rom[0] = 16'h9123;
        start_run(0, 4);
        len = 0;
        while (state != 3'd3 && len < 20) begin
            @(negedge clk);
            len++;
        end
        check("reach mem", state, 3);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid-mem reset state", state, 0);
        check("mid-mem reset outputs", {rom_addr, rom_en, ram_req, done, retired}, 0);
        check("mid-mem reset fields", {opcode, rd, rs, rt}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart state", state, 1);
        check("restart pc", rom_addr, 0);
        wait_done("restart");
        check("restart retired", retired, 1);

        for (int it = 0; it < 6; it++) begin
            off = int'($urandom_range(0, 31)) * 2 + 1;
            len = int'($urandom_range(5, 12));
            for (int a = 0; a < 64; a++) begin
                rop  = 4'($urandom_range(0, 14));
                rlow = 12'($urandom);
                rom[a]     = {rop, rlow};
                off_tab[a] = 6'(off);
            end
            rom[(len * off) % 64] = c_HALT;
            run_prog("random", it % 3, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
